uart_midi_tx: RTL and testbench
===============================

// Module: uart_midi_tx
// PURPOSE
//   Serial MIDI transmitter, the send-side counterpart of uart_midi_rx. Accepts one packed
//   MIDI event per handshake and serializes its 1, 2 or 3 bytes as 8N1 UART frames on tx_out.
//   Frame count comes from the status byte. Running status is optional. Sits in clk_98_3mhz
//   domain, drives MIDI out (uart_txd) for echo/thru of synthesizer events.
// PARAMETERS
//   BAUD_CYCLES     3147  clk_in cycles per bit (98.333MHz / 31250 baud, rounded)
//   RUNNING_STATUS  1     1: omit status byte when equal to last sent channel-voice status
// PORTS
//   clk_in         in   1   system clock (clk_98_3mhz)
//   rst_in         in   1   reset, asynchronous, active-low (0 = reset)
//   valid_in       in   1   midi_event_in valid; transfer when valid_in && ready_out
//   midi_event_in  in   24  [23:16] status, [15:8] data1, [7:0] data2
//   ready_out      out  1   high only in IDLE; block can accept an event
//   tx_out         out  1   UART line, idle high
//   busy_out       out  1   high while any frame is on the line
//   done_out       out  1   1-cycle pulse at end of the event's final stop bit
// BEHAVIOUR
//   Reset (rst_in=0, async): state IDLE, tx_out=1, ready_out=1, busy_out=0, done_out=0,
//     last_status cleared (no running status). Reset mid-frame aborts at once, line high.
//   Length from status S: 0x80-0xBF,0xE0-0xEF -> 3 B; 0xC0-0xDF -> 2 B; 0xF8-0xFF -> 1 B;
//     0xF1,0xF3 -> 2 B; 0xF2 -> 3 B; 0xF0,0xF4-0xF7 -> 1 B; S[7]=0 -> invalid.
//   Running status (RUNNING_STATUS=1): S in 0x80-0xEF and S==last_status -> skip status byte.
//     Any sent 0x80-0xEF sets last_status=S. 0xF0-0xF7 clears it. 0xF8-0xFF leaves it.
//   Invalid event: accepted (handshake completes) and dropped. No line activity, no done_out,
//     last_status unchanged, ready_out stays 1.
//   FSM IDLE -> START -> DATA -> STOP -> (START if bytes remain | IDLE).
//     IDLE : ready_out=1, tx_out=1. Valid accept latches event, byte count and first byte.
//       Next cycle enters START.
//     START: tx_out=0 for BAUD_CYCLES cycles.
//     DATA : 8 bits LSB first, BAUD_CYCLES cycles each, bit index 0..7.
//     STOP : tx_out=1 for BAUD_CYCLES cycles. Then load the next byte (status, data1, data2
//       order) with no inter-byte gap, or finish.
//   On finish: done_out=1 and state=IDLE (ready_out=1) in the same cycle. An event may be
//     accepted in that cycle.
//   Latency: accept at cycle T -> start bit edge at T+1. N-byte event occupies the line for
//     exactly N*10*BAUD_CYCLES cycles. done_out at T+N*10*BAUD_CYCLES.
//   valid_in while ready_out=0 is ignored (no queue). Input is not sampled after accept.
//   Baud counter: $clog2(BAUD_CYCLES) bits, 0..BAUD_CYCLES-1, wraps per bit. No drift
//     across bytes.
//   busy_out = (state != IDLE). tx_out is registered (glitch-free).
// TESTING (bench uses BAUD_CYCLES=4)
//   Note-on 0x903C64 at T -> tx bit sequence 0,00001001,1 | 0,00111100,1 | 0,00100110,1
//     (LSB first); 120 cycles; done_out at T+120.
//   Program change 0xC507xx -> 2 frames (0xC5, 0x07) only; done_out at T+80.
//   Back-to-back 0x903C64, 0x903E64 (RUNNING_STATUS=1) -> second sends 0x3E, 0x64 only
//     (80 cycles). Repeat with RUNNING_STATUS=0 -> second sends 3 frames.
//   Running status across 0xF8xxxx -> 0x903C64, 0xF8, 0x903E64 sends 3+1+2 frames.
//     Insert 0xF6 instead -> 3+1+3 frames.
//   Invalid 0x3C4000 -> accepted, tx_out stays 1 for 200 cycles, no done_out, ready_out=1.
//   rst_in pulled low mid-DATA of frame 2 -> tx_out=1, ready_out=1 immediately.
//     Next 0x903C64 sends 3 frames (status not skipped).

Source files
------------

// File: rtl/uart_midi_tx.sv
// uart_midi_tx
//   Serial MIDI transmitter. One packed MIDI event is taken per valid/ready
//   handshake. Its 1, 2 or 3 bytes are sent as back-to-back 8N1 UART frames,
//   LSB first. The status byte sets the byte count. Running status can
//   optionally drop a repeated channel-voice status byte.
//
//   Ports
//     clk_in         system clock
//     rst_in         asynchronous reset, active low
//     valid_in       midi_event_in valid; transfer when valid_in && ready_out
//     midi_event_in  [23:16] status, [15:8] data1, [7:0] data2
//     ready_out      high only while idle
//     tx_out         registered UART line, idle high
//     busy_out       high while a frame is on the line
//     done_out       one-cycle pulse when the event's last stop bit ends
module uart_midi_tx #(
    parameter int BAUD_CYCLES    = 3147,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [23:0] midi_event_in,
    output logic        ready_out,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int               CNT_W    = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [1:0]       r_left, w_left_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_done, w_done_nxt;
    logic [7:0]       r_last_status, w_last_status_nxt;
    logic             r_last_vld, w_last_vld_nxt;
    logic [7:0]       r_cur, w_cur_nxt;
    logic [7:0]       r_nxt1, w_nxt1_nxt;
    logic [7:0]       r_nxt2, w_nxt2_nxt;

    logic [7:0]       w_status;
    logic [1:0]       w_len;
    logic             w_is_chan;
    logic             w_skip;

    // Byte count implied by a status byte; 0 marks an invalid event.
    function automatic logic [1:0] f_event_len(input logic [7:0] s);
        if (!s[7])
            return 2'd0;
        else if (s[7:4] != 4'hF)
            return (s[6:5] == 2'b10) ? 2'd2 : 2'd3;   // 0xC0-0xDF carry one data byte
        else begin
            case (s[3:0])
                4'h1, 4'h3: return 2'd2;
                4'h2:       return 2'd3;
                default:    return 2'd1;
            endcase
        end
    endfunction

    assign w_status  = midi_event_in[23:16];
    assign w_len     = f_event_len(w_status);
    assign w_is_chan = w_status[7] && (w_status[7:4] != 4'hF);
    assign w_skip    = RUNNING_STATUS && w_is_chan && r_last_vld && (w_status == r_last_status);

    always_comb begin
        w_state_nxt       = r_state;
        w_baud_cnt_nxt    = r_baud_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_left_nxt        = r_left;
        w_tx_nxt          = r_tx;
        w_done_nxt        = 1'b0;
        w_last_status_nxt = r_last_status;
        w_last_vld_nxt    = r_last_vld;
        w_cur_nxt         = r_cur;
        w_nxt1_nxt        = r_nxt1;
        w_nxt2_nxt        = r_nxt2;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                // Invalid events complete the handshake but are simply dropped.
                if (valid_in && (w_len != 2'd0)) begin
                    w_state_nxt    = S_START;
                    w_baud_cnt_nxt = '0;
                    w_tx_nxt       = 1'b0;
                    if (w_skip) begin
                        w_cur_nxt  = midi_event_in[15:8];
                        w_nxt1_nxt = midi_event_in[7:0];
                        w_left_nxt = w_len - 2'd2;
                    end else begin
                        w_cur_nxt  = w_status;
                        w_nxt1_nxt = midi_event_in[15:8];
                        w_nxt2_nxt = midi_event_in[7:0];
                        w_left_nxt = w_len - 2'd1;
                    end
                    // Channel voice arms running status, system common clears it,
                    // real-time (0xF8-0xFF) leaves it alone.
                    if (w_is_chan) begin
                        w_last_status_nxt = w_status;
                        w_last_vld_nxt    = 1'b1;
                    end else if (!w_status[3]) begin
                        w_last_status_nxt = 8'h00;
                        w_last_vld_nxt    = 1'b0;
                    end
                end
            end
            S_START: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_state_nxt    = S_DATA;
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_nxt       = r_cur[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_cur[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_baud_cnt_nxt = '0;
                    if (r_left != 2'd0) begin
                        // Next byte starts right after the stop bit, no idle gap.
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                        w_cur_nxt   = r_nxt1;
                        w_nxt1_nxt  = r_nxt2;
                        w_left_nxt  = r_left - 2'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= S_IDLE;
            r_baud_cnt    <= '0;
            r_bit_idx     <= 3'd0;
            r_left        <= 2'd0;
            r_tx          <= 1'b1;
            r_done        <= 1'b0;
            r_last_status <= 8'h00;
            r_last_vld    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_baud_cnt    <= w_baud_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_left        <= w_left_nxt;
            r_tx          <= w_tx_nxt;
            r_done        <= w_done_nxt;
            r_last_status <= w_last_status_nxt;
            r_last_vld    <= w_last_vld_nxt;
        end
    end

    // Byte holding registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk_in) begin
        r_cur  <= w_cur_nxt;
        r_nxt1 <= w_nxt1_nxt;
        r_nxt2 <= w_nxt2_nxt;
    end

    assign ready_out = (r_state == S_IDLE);
    assign busy_out  = (r_state != S_IDLE);
    assign tx_out    = r_tx;
    assign done_out  = r_done;

endmodule

// File: tb/tb_uart_midi_tx.sv
module tb_uart_midi_tx;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid1, valid0;
    logic [23:0] ev1, ev0;
    logic        ready1, tx1, busy1, done1;
    logic        ready0, tx0, busy0, done0;

    always #5 clk = ~clk;

    uart_midi_tx #(.BAUD_CYCLES(B), .RUNNING_STATUS(1'b1)) dut (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid1), .midi_event_in(ev1),
        .ready_out(ready1), .tx_out(tx1), .busy_out(busy1), .done_out(done1));

    uart_midi_tx #(.BAUD_CYCLES(B), .RUNNING_STATUS(1'b0)) dut_nors (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid0), .midi_event_in(ev0),
        .ready_out(ready0), .tx_out(tx0), .busy_out(busy0), .done_out(done0));

    int checks   = 0;
    int failures = 0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];

    typedef struct {
        logic [23:0] ev;
        int          n;
        logic [23:0] exp;   // expected bytes on the line, first byte in [23:16]
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Decodes frames from one DUT's line and compares against its queue.
    task automatic monitor(input bit which);
        logic [10*B-1:0] s;
        logic [7:0]      b;
        bit              ok, abort;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ((which ? tx1 : tx0) === 1'b0)) begin
                s = '0;
                abort = 1'b0;
                for (int i = 1; i < 10*B; i++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    s[i] = which ? tx1 : tx0;
                end
                if (!abort) begin
                    ok = 1'b1;
                    for (int j = 0; j < 10; j++)
                        for (int k = 0; k < B; k++)
                            if (s[j*B+k] !== s[j*B]) ok = 1'b0;
                    for (int j = 0; j < 8; j++) b[j] = s[(j+1)*B];
                    chk(which ? "frame_shape" : "nors_frame_shape", {31'd0, ok}, 32'd1);
                    chk(which ? "stop_bit" : "nors_stop_bit", {31'd0, s[9*B]}, 32'd1);
                    if (which) begin
                        chk("frame_expected", {31'd0, q1.size() != 0}, 32'd1);
                        if (q1.size() != 0) chk("frame_byte", {24'd0, b}, {24'd0, q1.pop_front()});
                    end else begin
                        chk("nors_frame_expected", {31'd0, q0.size() != 0}, 32'd1);
                        if (q0.size() != 0) chk("nors_frame_byte", {24'd0, b}, {24'd0, q0.pop_front()});
                    end
                end
            end
        end
    endtask

    initial monitor(1'b1);
    initial monitor(1'b0);

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit which, input logic [23:0] e, output time t_acc);
        int n = 0;
        while (((which ? ready1 : ready0) !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", {31'd0, which ? ready1 : ready0}, 32'd1);
        if (which) begin ev1 = e; valid1 = 1'b1; end
        else       begin ev0 = e; valid0 = 1'b1; end
        @(posedge clk);
        t_acc = $time;
        #1;
        // Scramble the bus: the DUT must not look at it after accepting.
        if (which) begin valid1 = 1'b0; ev1 = 24'($urandom); end
        else       begin valid0 = 1'b0; ev0 = 24'($urandom); end
        @(negedge clk);
    endtask

    task automatic wait_done(input bit which, input time t_acc, input int exp_cycles, input string name);
        int n = 0;
        int lat;
        while (((which ? done1 : done0) !== 1'b1) && n < exp_cycles + 60) begin
            @(negedge clk);
            n++;
        end
        lat = ((which ? done1 : done0) === 1'b1) ? int'(($time - 5 - t_acc) / 10) : -1;
        chk(name, lat, exp_cycles);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t;
        bit  quiet;

        tbl[0]  = '{24'h903C64, 3, 24'h903C64};
        tbl[1]  = '{24'h903E64, 2, 24'h3E6400};
        tbl[2]  = '{24'hC50711, 2, 24'hC50700};
        tbl[3]  = '{24'hC50811, 1, 24'h080000};
        tbl[4]  = '{24'hF81234, 1, 24'hF80000};
        tbl[5]  = '{24'hC50911, 1, 24'h090000};
        tbl[6]  = '{24'hF60000, 1, 24'hF60000};
        tbl[7]  = '{24'hC50A11, 2, 24'hC50A00};
        tbl[8]  = '{24'h3C4000, 0, 24'h000000};
        tbl[9]  = '{24'hC50B00, 1, 24'h0B0000};
        tbl[10] = '{24'hF20102, 3, 24'hF20102};
        tbl[11] = '{24'hF30500, 2, 24'hF30500};
        tbl[12] = '{24'hE01020, 3, 24'hE01020};
        tbl[13] = '{24'hE01121, 2, 24'h112100};
        tbl[14] = '{24'hFF0000, 1, 24'hFF0000};
        tbl[15] = '{24'hE01222, 2, 24'h122200};
        tbl[16] = '{24'hF17F00, 2, 24'hF17F00};
        tbl[17] = '{24'hF00000, 1, 24'hF00000};
        tbl[18] = '{24'hB07B00, 3, 24'hB07B00};
        tbl[19] = '{24'h903C64, 3, 24'h903C64};
        tbl[20] = '{24'hF80000, 1, 24'hF80000};
        tbl[21] = '{24'h903E64, 2, 24'h3E6400};
        tbl[22] = '{24'hF60000, 1, 24'hF60000};
        tbl[23] = '{24'h903E64, 3, 24'h903E64};

        rst_n = 1'b0; valid1 = 1'b0; valid0 = 1'b0; ev1 = '0; ev0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    {31'd0, tx1},    32'd1);
        chk("rst_ready", {31'd0, ready1}, 32'd1);
        chk("rst_busy",  {31'd0, busy1},  32'd0);
        chk("rst_done",  {31'd0, done1},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < tbl[i].n; k++) q1.push_back(tbl[i].exp[23-8*k -: 8]);
            send(1'b1, tbl[i].ev, t);
            if (tbl[i].n == 0) begin
                chk("invalid_ready", {31'd0, ready1}, 32'd1);
                quiet = 1'b1;
                repeat (200) begin
                    if (tx1 !== 1'b1 || done1 !== 1'b0 || ready1 !== 1'b1 || busy1 !== 1'b0) quiet = 1'b0;
                    @(negedge clk);
                end
                chk("invalid_quiet", {31'd0, quiet}, 32'd1);
            end else begin
                chk("busy_during", {30'd0, busy1, ready1}, 32'd2);
                wait_done(1'b1, t, tbl[i].n * 10 * B, "done_latency");
                chk("all_frames_seen", q1.size(), 32'd0);
            end
        end

        @(negedge clk);
        chk("done_pulse_width", {31'd0, done1}, 32'd0);

        // valid_in while busy is ignored
        q1.push_back(8'hA0); q1.push_back(8'h12); q1.push_back(8'h34);
        send(1'b1, 24'hA01234, t);
        repeat (20) begin
            ev1 = 24'hC07F00; valid1 = 1'b1;
            @(negedge clk);
        end
        valid1 = 1'b0;
        wait_done(1'b1, t, 120, "busy_ignore_latency");
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || done1 !== 1'b0) quiet = 1'b0;
        end
        chk("busy_ignore_quiet", {31'd0, quiet}, 32'd1);
        chk("busy_ignore_frames", q1.size(), 32'd0);

        // reset in the middle of the second frame
        q1.push_back(8'h90); q1.push_back(8'h33); q1.push_back(8'h44);
        send(1'b1, 24'h903344, t);
        repeat (51) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",    {31'd0, tx1},    32'd1);
        chk("midrst_ready", {31'd0, ready1}, 32'd1);
        chk("midrst_busy",  {31'd0, busy1},  32'd0);
        chk("midrst_done",  {31'd0, done1},  32'd0);
        chk("midrst_frames_before", q1.size(), 32'd2);
        q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q1.push_back(8'h90); q1.push_back(8'h3C); q1.push_back(8'h64);
        send(1'b1, 24'h903C64, t);
        wait_done(1'b1, t, 120, "post_rst_latency");
        chk("post_rst_frames", q1.size(), 32'd0);

        // running status disabled: repeated status is always sent
        q0.push_back(8'h90); q0.push_back(8'h3C); q0.push_back(8'h64);
        send(1'b0, 24'h903C64, t);
        wait_done(1'b0, t, 120, "nors_latency1");
        q0.push_back(8'h90); q0.push_back(8'h3E); q0.push_back(8'h64);
        send(1'b0, 24'h903E64, t);
        wait_done(1'b0, t, 120, "nors_latency2");
        chk("nors_frames", q0.size(), 32'd0);

        repeat (20) @(negedge clk);
        chk("final_q1_empty", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
